tag_ctrl_sched: RTL and testbench

//  Scheduler for the 32-entry tag FIFO in the rename/dispatch path. Dispatch side: grants one
//  tag per cycle to an instruction with a destination register. Retire side: accepts returning

---
 rtl/tag_ctrl_sched_if.sv | 58 +++++
 rtl/tag_ctrl_sched.sv | 98 +++++++++
 tb/tb_tag_ctrl_sched.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tag_ctrl_sched_if.sv
// Tag scheduler bus: dispatch grant, retire return and tag FIFO ports.
// Clock and reset stay plain ports on the scheduler itself.
interface tag_ctrl_sched_if #(
  parameter int DSIZE = 5,
  parameter int NREQ  = 4
);
  logic                   disp_req;
  logic                   disp_has_rd;
  logic                   disp_grant;
  logic [DSIZE-1:0]       disp_tag;
  logic [NREQ-1:0]        ret_valid;
  logic [NREQ*DSIZE-1:0]  ret_tag;
  logic [NREQ-1:0]        ret_ready;
  logic [DSIZE-1:0]       Tag_Out;
  logic                   tagFifo_empty;
  logic                   Rd_en;
  logic                   increment;
  logic [DSIZE-1:0]       RB_Tag;
  logic                   RB_Tag_Valid;
  logic [DSIZE:0]         credit_cnt;
  logic                   err_ovf;

  modport slave (
    input  disp_req,
    input  disp_has_rd,
    input  ret_valid,
    input  ret_tag,
    input  Tag_Out,
    input  tagFifo_empty,
    output disp_grant,
    output disp_tag,
    output ret_ready,
    output Rd_en,
    output increment,
    output RB_Tag,
    output RB_Tag_Valid,
    output credit_cnt,
    output err_ovf
  );

  modport master (
    output disp_req,
    output disp_has_rd,
    output ret_valid,
    output ret_tag,
    output Tag_Out,
    output tagFifo_empty,
    input  disp_grant,
    input  disp_tag,
    input  ret_ready,
    input  Rd_en,
    input  increment,
    input  RB_Tag,
    input  RB_Tag_Valid,
    input  credit_cnt,
    input  err_ovf
  );
endinterface

// File: rtl/tag_ctrl_sched.sv
// Tag FIFO scheduler: dispatch-side grant, retire-side holding
// registers and round-robin write-port arbitration with credits.
module tag_ctrl_sched #(
  parameter int DSIZE = 5,
  parameter int NREQ  = 4
) (
  input  logic clock,
  input  logic reset,
  tag_ctrl_sched_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = DSIZE + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(1) << DSIZE;

  logic [NREQ-1:0]            pend_v;
  logic [NREQ-1:0][DSIZE-1:0] pend_tag;
  logic [PW-1:0]              rr_ptr;
  logic [DSIZE-1:0]           rb_tag;
  logic                       rb_vld;
  logic [CW-1:0]              credit;
  logic                       err;

  logic                       grant;
  logic                       any_pend;
  logic [PW-1:0]              win;
  logic [PW-1:0]              win_nxt;
  logic [PW-1:0]              idx;
  logic                       found;
  logic [CW-1:0]              cnt_after;
  logic                       issue_ok;
  logic                       issue;

  assign grant = bus.disp_req
               & bus.disp_has_rd
               & ~bus.tagFifo_empty;

  assign bus.disp_grant   = grant;
  assign bus.Rd_en        = grant;
  assign bus.increment    = grant;
  assign bus.disp_tag     = bus.Tag_Out;
  assign bus.ret_ready    = ~pend_v;
  assign bus.RB_Tag       = rb_tag;
  assign bus.RB_Tag_Valid = rb_vld;
  assign bus.credit_cnt   = credit;
  assign bus.err_ovf      = err;

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (!found && pend_v[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign any_pend = |pend_v;
  assign win_nxt  = (win == PW'(NREQ - 1))
                  ? '0 : win + PW'(1);

  // A same-cycle grant frees a slot the issue may use.
  assign cnt_after = credit - CW'(grant);
  assign issue_ok  = cnt_after < DEPTH_C;
  assign issue     = any_pend & issue_ok;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_v   <= '0;
      pend_tag <= '0;
      rr_ptr   <= '0;
      rb_tag   <= '0;
      rb_vld   <= 1'b0;
      credit   <= DEPTH_C;
      err      <= 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (issue && win == PW'(i)) begin
          pend_v[i] <= 1'b0;
        end else if (!pend_v[i] && bus.ret_valid[i]) begin
          pend_v[i]   <= 1'b1;
          pend_tag[i] <= bus.ret_tag[i*DSIZE +: DSIZE];
        end
      end
      rb_vld <= issue;
      if (issue) begin
        rb_tag <= pend_tag[win];
        rr_ptr <= win_nxt;
      end
      credit <= cnt_after + CW'(issue);
      if (any_pend && !issue_ok) begin
        err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tag_ctrl_sched.sv
// Bench for tag_ctrl_sched: queue-based FIFO environment, abstract
// scheduler model checked every cycle, plus literal expectations.
module tb_tag_ctrl_sched;
  localparam int DSIZE = 5;
  localparam int NREQ  = 4;
  localparam int DEPTH = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tag_ctrl_sched_if #(.DSIZE(DSIZE), .NREQ(NREQ)) bus();

  tag_ctrl_sched #(.DSIZE(DSIZE), .NREQ(NREQ)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int fifo_q[$];
  int rb_log[$];
  int gnt_log[$];
  int m_pv[NREQ];
  int m_pt[NREQ];
  int m_rr, m_cr, m_err, m_rbv, m_rbt;

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  function automatic int exp_ready();
    int r = 0;
    for (int i = 0; i < NREQ; i++)
      if (m_pv[i] == 0) r |= (1 << i);
    return r;
  endfunction

  task automatic fifo_drive();
    bus.tagFifo_empty = (fifo_q.size() == 0);
    bus.Tag_Out = (fifo_q.size() == 0) ? '0 : DSIZE'(fifo_q[0]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_pv[i] = 0;
      m_pt[i] = 0;
    end
    m_rr = 0; m_cr = DEPTH; m_err = 0;
    m_rbv = 0; m_rbt = 0;
    fifo_q = {};
    for (int t = 0; t < DEPTH; t++) fifo_q.push_back(t);
    fifo_drive();
  endtask

  task automatic set_in(int req, int hrd, int rv,
                        int t0, int t1, int t2, int t3);
    bus.disp_req    = req[0];
    bus.disp_has_rd = hrd[0];
    bus.ret_valid   = NREQ'(rv);
    bus.ret_tag = {DSIZE'(t3), DSIZE'(t2), DSIZE'(t1), DSIZE'(t0)};
  endtask

  // One clock: compare against the model, advance model and FIFO.
  task automatic cyc();
    int g, w, ok, iss, wr, wt, rd;
    int npv[NREQ];
    int npt[NREQ];
    #1;
    g = (bus.disp_req && bus.disp_has_rd && fifo_q.size() != 0) ? 1 : 0;
    chk("disp_grant", int'(bus.disp_grant), g);
    chk("rd_en", int'(bus.Rd_en), g);
    chk("increment", int'(bus.increment), g);
    if (g != 0) begin
      chk("disp_tag", int'(bus.disp_tag), fifo_q[0]);
      gnt_log.push_back(int'(bus.disp_tag));
    end
    chk("ret_ready", int'(bus.ret_ready), exp_ready());
    chk("rb_valid", int'(bus.RB_Tag_Valid), m_rbv);
    chk("rb_tag", int'(bus.RB_Tag), m_rbt);
    chk("credit", int'(bus.credit_cnt), m_cr);
    chk("err_ovf", int'(bus.err_ovf), m_err);
    wr = int'(bus.RB_Tag_Valid);
    wt = int'(bus.RB_Tag);
    rd = int'(bus.Rd_en);
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && m_pv[(m_rr + k) % NREQ] != 0) w = (m_rr + k) % NREQ;
    ok  = ((m_cr - g) < DEPTH) ? 1 : 0;
    iss = (w >= 0 && ok != 0) ? 1 : 0;
    if (w >= 0 && ok == 0) m_err = 1;
    for (int i = 0; i < NREQ; i++) begin
      npv[i] = m_pv[i];
      npt[i] = m_pt[i];
      if (iss != 0 && w == i) npv[i] = 0;
      else if (m_pv[i] == 0 && bus.ret_valid[i]) begin
        npv[i] = 1;
        npt[i] = int'(bus.ret_tag[i*DSIZE +: DSIZE]);
      end
    end
    m_rbv = iss;
    if (iss != 0) begin
      m_rbt = m_pt[w];
      m_rr  = (w + 1) % NREQ;
    end
    m_cr = m_cr - g + iss;
    m_pv = npv;
    m_pt = npt;
    @(posedge clock);
    #1;
    if (rd != 0 && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (wr != 0) fifo_q.push_back(wt);
    fifo_drive();
    if (bus.RB_Tag_Valid) rb_log.push_back(int'(bus.RB_Tag));
    @(negedge clock);
  endtask

  task automatic idle(int n);
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_credit", int'(bus.credit_cnt), 32);
    chk("rst_ready", int'(bus.ret_ready), 15);
    chk("rst_rbv", int'(bus.RB_Tag_Valid), 0);
    chk("rst_rbtag", int'(bus.RB_Tag), 0);
    chk("rst_err", int'(bus.err_ovf), 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    do_reset();

    // T2: drain all 32 tags, then one denied request
    gnt_log = {};
    set_in(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 33; i++) cyc();
    chk("t2_grants", gnt_log.size(), 32);
    for (int i = 0; i < gnt_log.size(); i++) chk("t2_tag", gnt_log[i], i);
    chk("t2_credit", int'(bus.credit_cnt), 0);
    #1;
    chk("t2_last_grant", int'(bus.disp_grant), 0);

    // T3: four returns in one cycle
    rb_log = {};
    set_in(0, 0, 15, 7, 3, 9, 1);
    cyc();
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("t3_first_tag", int'(bus.RB_Tag), 7);
    chk("t3_ready0", int'(bus.ret_ready), 1);
    idle(6);
    chk("t3_count", rb_log.size(), 4);
    if (rb_log.size() == 4) begin
      chk("t3_o0", rb_log[0], 7);
      chk("t3_o1", rb_log[1], 3);
      chk("t3_o2", rb_log[2], 9);
      chk("t3_o3", rb_log[3], 1);
    end
    chk("t3_credit", int'(bus.credit_cnt), 4);

    // No destination register: FIFO not empty, yet no read
    set_in(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("no_rd_empty", int'(bus.tagFifo_empty), 0);
    chk("no_rd", int'(bus.Rd_en), 0);
    cyc();
    cyc();

    // T4: move rr_ptr to 2, then pend 4'b1011
    rb_log = {};
    set_in(0, 0, 2, 0, 12, 0, 0);
    cyc();
    idle(2);
    set_in(0, 0, 11, 20, 21, 0, 23);
    cyc();
    idle(5);
    chk("t4_count", rb_log.size(), 4);
    if (rb_log.size() == 4) begin
      chk("t4_o0", rb_log[0], 12);
      chk("t4_o1", rb_log[1], 23);
      chk("t4_o2", rb_log[2], 20);
      chk("t4_o3", rb_log[3], 21);
    end
    chk("t4_credit", int'(bus.credit_cnt), 8);

    // T5: grant+issue cancel at 31, then block at 32
    do_reset();
    set_in(1, 1, 0, 0, 0, 0, 0);
    cyc();
    set_in(0, 0, 1, 5, 0, 0, 0);
    cyc();
    set_in(1, 1, 0, 0, 0, 0, 0);
    cyc();
    chk("t5_credit31", int'(bus.credit_cnt), 31);
    chk("t5_rbv", int'(bus.RB_Tag_Valid), 1);
    chk("t5_rbtag", int'(bus.RB_Tag), 5);
    chk("t5_err0", int'(bus.err_ovf), 0);
    idle(2);
    set_in(0, 0, 2, 0, 6, 0, 0);
    cyc();
    idle(2);
    chk("t5_credit32", int'(bus.credit_cnt), 32);
    set_in(0, 0, 4, 0, 0, 8, 0);
    cyc();
    idle(1);
    chk("t5_err1", int'(bus.err_ovf), 1);
    chk("t5_held", int'(bus.ret_ready), 11);
    chk("t5_blk_rbv", int'(bus.RB_Tag_Valid), 0);
    set_in(1, 1, 0, 0, 0, 0, 0);
    cyc();
    chk("t5_drain_tag", int'(bus.RB_Tag), 8);
    chk("t5_drain_cr", int'(bus.credit_cnt), 32);
    idle(2);

    // T6: reset with 3 pending and a write in flight
    do_reset();
    set_in(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc();
    set_in(0, 0, 15, 10, 11, 12, 13);
    cyc();
    idle(1);
    chk("t6_pre_rbv", int'(bus.RB_Tag_Valid), 1);
    chk("t6_pre_ready", int'(bus.ret_ready), 1);
    do_reset();
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end
endmodule
